// File: rtl/mem_sweep_ctrl_pkg.sv
// Shared types, constants and the LFSR step function for the RAM sweep controller.
package mem_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    VERIFY,
    DRAIN,
    DONE
  } sweep_state_t;

  localparam int LFSR_W = 16;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] ERR_SAT = 16'hFFFF;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_sweep_ctrl_if.sv
// RAM-side bus between the sweep controller (master) and the block RAM wrapper (slave).
interface mem_sweep_if #(
  parameter int WID_MEM = 1
);
  logic [31:0]        raddr;
  logic [31:0]        waddr;
  logic [WID_MEM-1:0] din;
  logic               we;
  logic [WID_MEM-1:0] dout;

  modport master (output raddr, output waddr, output din, output we, input dout);
  modport slave  (input raddr, input waddr, input din, input we, output dout);
endinterface

// File: rtl/mem_sweep_ctrl_lfsr.sv
// Pattern generator: 16-bit Fibonacci LFSR with reload and step; exposes the low OUT_W bits.
module lfsr16
  import mem_sweep_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
  parameter int                OUT_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  output logic [OUT_W-1:0] value_q,
  output logic [OUT_W-1:0] value_d
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = SEED;
    end else if (step) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign value_q = state_q[OUT_W-1:0];
  assign value_d = state_d[OUT_W-1:0];

endmodule

// File: rtl/mem_sweep_ctrl.sv
// Fills a block RAM with an LFSR pattern and/or reads it back, counting mismatches.
module mem_sweep_ctrl
  import mem_sweep_pkg::*;
#(
  parameter int          WID_MEM   = 1,
  parameter int          DEPTH_MEM = 32768,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op_fill,
  mem_sweep_if.master  mem,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  err_count,
  output logic [31:0]  first_err_addr
);

  localparam int            AW        = $clog2(DEPTH_MEM);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH_MEM - 1);

  sweep_state_t       state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               lfsr_load, lfsr_step;
  logic [WID_MEM-1:0] lfsr_q, lfsr_d;
  logic [WID_MEM-1:0] exp_q, exp_d;
  logic [AW-1:0]      exp_addr_q, exp_addr_d;
  logic               exp_vld_q, exp_vld_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]        err_q, err_d;
  logic [AW-1:0]      first_q, first_d;
  logic               we_q, we_d;
  logic [WID_MEM-1:0] din_q, din_d;
  logic [AW-1:0]      waddr_q, waddr_d, raddr_q, raddr_d;

  lfsr16 #(.SEED(SEED), .OUT_W(WID_MEM)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (lfsr_load),
    .step    (lfsr_step),
    .value_q (lfsr_q),
    .value_d (lfsr_d)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    err_d      = err_q;
    first_d    = first_q;
    pass_d     = pass_q;
    // The word read this cycle returns next cycle, so its expectation travels one stage.
    exp_vld_d  = (state_q == VERIFY);
    exp_d      = lfsr_q;
    exp_addr_d = addr_q;

    if (exp_vld_q && (mem.dout != exp_q)) begin
      if (err_q != ERR_SAT) err_d = err_q + 16'd1;
      if (err_q == 16'd0)   first_d = exp_addr_q;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = op_fill ? FILL : VERIFY;
          addr_d    = '0;
          lfsr_load = 1'b1;
          err_d     = '0;
          first_d   = '0;
          pass_d    = 1'b0;
        end
      end
      FILL: begin
        if (addr_q == ADDR_LAST) begin
          state_d   = VERIFY;
          addr_d    = '0;
          lfsr_load = 1'b1;
        end else begin
          addr_d    = addr_q + 1'b1;
          lfsr_step = 1'b1;
        end
      end
      VERIFY: begin
        if (addr_q == ADDR_LAST) begin
          state_d = DRAIN;
        end else begin
          addr_d    = addr_q + 1'b1;
          lfsr_step = 1'b1;
        end
      end
      DRAIN: begin
        state_d = DONE;
        pass_d  = (err_d == 16'd0);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are computed from the next state so they are registered yet cycle-aligned.
    busy_d  = state_d inside {FILL, VERIFY, DRAIN};
    done_d  = (state_d == DONE);
    we_d    = (state_d == FILL);
    waddr_d = we_d ? addr_d : '0;
    din_d   = we_d ? lfsr_d : '0;
    raddr_d = (state_d == VERIFY) ? addr_d : raddr_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      exp_q      <= '0;
      exp_addr_q <= '0;
      exp_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      first_q    <= '0;
      we_q       <= 1'b0;
      din_q      <= '0;
      waddr_q    <= '0;
      raddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      exp_q      <= exp_d;
      exp_addr_q <= exp_addr_d;
      exp_vld_q  <= exp_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      first_q    <= first_d;
      we_q       <= we_d;
      din_q      <= din_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = 32'(first_q);
  assign mem.we         = we_q;
  assign mem.din        = din_q;
  assign mem.waddr      = 32'(waddr_q);
  assign mem.raddr      = 32'(raddr_q);

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Directed bench: two controllers (1-bit and 4-bit words, depth 16) each with a small RAM model.
module tb_mem_sweep_ctrl;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start1, op_fill1, busy1, done1, pass1;
  logic [15:0] err1;
  logic [31:0] ferr1;
  logic        start4, op_fill4, busy4, done4, pass4;
  logic [15:0] err4;
  logic [31:0] ferr4;

  mem_sweep_if #(.WID_MEM(1)) bus1 ();
  mem_sweep_if #(.WID_MEM(4)) bus4 ();

  mem_sweep_ctrl #(.WID_MEM(1), .DEPTH_MEM(DEPTH), .SEED(16'hACE1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op_fill(op_fill1), .mem(bus1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_err_addr(ferr1)
  );

  mem_sweep_ctrl #(.WID_MEM(4), .DEPTH_MEM(DEPTH), .SEED(16'hACE1)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .op_fill(op_fill4), .mem(bus4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4), .first_err_addr(ferr4)
  );

  // RAM models: registered read, write gated by we; poke port lets the bench alter contents.
  logic [0:0] ram1 [DEPTH];
  logic [3:0] ram4 [DEPTH];
  logic       poke1_en, poke4_en;
  logic [3:0] poke_addr;
  logic [0:0] poke1_data;
  logic [3:0] poke4_data;

  always @(posedge clk) begin
    if (poke1_en) ram1[poke_addr] <= poke1_data;
    else if (bus1.we) ram1[bus1.waddr[3:0]] <= bus1.din;
    bus1.dout <= ram1[bus1.raddr[3:0]];
  end

  always @(posedge clk) begin
    if (poke4_en) ram4[poke_addr] <= poke4_data;
    else if (bus4.we) ram4[bus4.waddr[3:0]] <= bus4.din;
    bus4.dout <= ram4[bus4.raddr[3:0]];
  end

  int          checks = 0;
  int          errors = 0;
  logic [15:0] pat [DEPTH];
  logic [0:0]  wcap1 [DEPTH];
  logic [3:0]  wcap4 [DEPTH];
  int          done_at, n_done, wcnt;
  logic        busy_first, we_first;

  function automatic logic [15:0] model_step(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  task automatic poke1(input int a, input logic [0:0] d);
    poke1_en = 1'b1; poke_addr = 4'(a); poke1_data = d;
    @(negedge clk);
    poke1_en = 1'b0;
  endtask

  task automatic poke4(input int a, input logic [3:0] d);
    poke4_en = 1'b1; poke_addr = 4'(a); poke4_data = d;
    @(negedge clk);
    poke4_en = 1'b0;
  endtask

  // Start accepted at the edge ending cycle 0; n counts cycles after it, sampled at negedge.
  task automatic run1(input logic fill, input bit repulse);
    @(negedge clk); start1 = 1'b1; op_fill1 = fill;
    @(negedge clk); start1 = 1'b0;
    done_at = -1; n_done = 0; wcnt = 0;
    busy_first = busy1; we_first = bus1.we;
    for (int i = 0; i < DEPTH; i++) wcap1[i] = 'x;
    for (int n = 1; n <= 60; n++) begin
      if (n > 1) @(negedge clk);
      if (repulse && n == 5) start1 = 1'b1;
      if (repulse && n == 6) start1 = 1'b0;
      if (bus1.we) begin wcap1[bus1.waddr[3:0]] = bus1.din; wcnt++; end
      if (done1) begin n_done++; if (done_at < 0) done_at = n; end
    end
  endtask

  task automatic run4(input logic fill);
    @(negedge clk); start4 = 1'b1; op_fill4 = fill;
    @(negedge clk); start4 = 1'b0;
    done_at = -1; n_done = 0; wcnt = 0;
    for (int i = 0; i < DEPTH; i++) wcap4[i] = 'x;
    for (int n = 1; n <= 60; n++) begin
      if (n > 1) @(negedge clk);
      if (bus4.we) begin wcap4[bus4.waddr[3:0]] = bus4.din; wcnt++; end
      if (done4) begin n_done++; if (done_at < 0) done_at = n; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done1); end
    checks++; if (pass1 !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", pass1); end
    checks++; if (err1 !== 16'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err1); end
    checks++; if (ferr1 !== 32'd0) begin errors++; $display("FAIL reset_ferr: got %0d expected 0", ferr1); end
    checks++; if (bus1.we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus1.we); end
    checks++; if (bus4.din !== 4'd0) begin errors++; $display("FAIL reset_din: got %h expected 0", bus4.din); end
    checks++; if (bus1.raddr !== 32'd0 || bus1.waddr !== 32'd0) begin
      errors++; $display("FAIL reset_addr: got r=%0d w=%0d expected 0/0", bus1.raddr, bus1.waddr);
    end
  endtask

  task automatic test_fill_verify;
    int bad;
    run1(1'b1, 1'b0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (wcap1[i] !== pat[i][0:0]) bad++;
    checks++; if (busy_first !== 1'b1 || we_first !== 1'b1) begin
      errors++; $display("FAIL fv_cycle1: got busy=%b we=%b expected 1/1", busy_first, we_first);
    end
    checks++; if (wcnt !== DEPTH) begin errors++; $display("FAIL fv_writes: got %0d expected %0d", wcnt, DEPTH); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL fv_pattern: got %0d bad words expected 0", bad); end
    checks++; if (done_at !== 34) begin errors++; $display("FAIL fv_done_cycle: got %0d expected 34", done_at); end
    checks++; if (pass1 !== 1'b1 || err1 !== 16'd0) begin
      errors++; $display("FAIL fv_result: got pass=%b err=%0d expected 1/0", pass1, err1);
    end
  endtask

  task automatic test_verify_only;
    for (int i = 0; i < DEPTH; i++) poke1(i, pat[i][0:0]);
    run1(1'b0, 1'b0);
    checks++; if (done_at !== 18) begin errors++; $display("FAIL vo_done_cycle: got %0d expected 18", done_at); end
    checks++; if (wcnt !== 0) begin errors++; $display("FAIL vo_writes: got %0d expected 0", wcnt); end
    checks++; if (pass1 !== 1'b1 || err1 !== 16'd0) begin
      errors++; $display("FAIL vo_result: got pass=%b err=%0d expected 1/0", pass1, err1);
    end
  endtask

  task automatic test_single_error;
    poke1(5, ~pat[5][0:0]);
    run1(1'b0, 1'b0);
    checks++; if (err1 !== 16'd1) begin errors++; $display("FAIL se_err: got %0d expected 1", err1); end
    checks++; if (ferr1 !== 32'd5) begin errors++; $display("FAIL se_first: got %0d expected 5", ferr1); end
    checks++; if (pass1 !== 1'b0) begin errors++; $display("FAIL se_pass: got %b expected 0", pass1); end
  endtask

  task automatic test_back_to_back;
    poke1(5, pat[5][0:0]);
    run1(1'b0, 1'b1);
    checks++; if (n_done !== 1) begin errors++; $display("FAIL bb_done_pulses: got %0d expected 1", n_done); end
    checks++; if (done_at !== 18) begin errors++; $display("FAIL bb_done_cycle: got %0d expected 18", done_at); end
    checks++; if (pass1 !== 1'b1 || ferr1 !== 32'd0) begin
      errors++; $display("FAIL bb_result: got pass=%b ferr=%0d expected 1/0", pass1, ferr1);
    end
  endtask

  task automatic test_reset_mid_fill;
    @(negedge clk); start1 = 1'b1; op_fill1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (bus1.we !== 1'b1 || bus1.waddr !== 32'd6) begin
      errors++; $display("FAIL rm_pre: got we=%b waddr=%0d expected 1/6", bus1.we, bus1.waddr);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy1 !== 1'b0 || bus1.we !== 1'b0 || bus1.waddr !== 32'd0) begin
      errors++; $display("FAIL rm_cleared: got busy=%b we=%b waddr=%0d expected 0/0/0", busy1, bus1.we, bus1.waddr);
    end
    reset = 1'b1;
    run1(1'b1, 1'b0);
    checks++; if (done_at !== 34 || pass1 !== 1'b1) begin
      errors++; $display("FAIL rm_rerun: got done_at=%0d pass=%b expected 34/1", done_at, pass1);
    end
  endtask

  task automatic test_inverted;
    run4(1'b1);
    // Low nibbles of ACE1, 59C3, B387, 670F.
    checks++; if (wcap4[0] !== 4'h1 || wcap4[1] !== 4'h3 || wcap4[2] !== 4'h7 || wcap4[3] !== 4'hF) begin
      errors++; $display("FAIL w4_first_words: got %h %h %h %h expected 1 3 7 f", wcap4[0], wcap4[1], wcap4[2], wcap4[3]);
    end
    checks++; if (done_at !== 34 || pass4 !== 1'b1) begin
      errors++; $display("FAIL w4_fill: got done_at=%0d pass=%b expected 34/1", done_at, pass4);
    end
    for (int i = 0; i < DEPTH; i++) poke4(i, ~pat[i][3:0]);
    run4(1'b0);
    checks++; if (err4 !== 16'd16) begin errors++; $display("FAIL inv_err: got %0d expected 16", err4); end
    checks++; if (ferr4 !== 32'd0) begin errors++; $display("FAIL inv_first: got %0d expected 0", ferr4); end
    checks++; if (pass4 !== 1'b0 || done_at !== 18) begin
      errors++; $display("FAIL inv_result: got pass=%b done_at=%0d expected 0/18", pass4, done_at);
    end
  endtask

  initial begin
    reset = 1'b0;
    start1 = 1'b0; op_fill1 = 1'b0; start4 = 1'b0; op_fill4 = 1'b0;
    poke1_en = 1'b0; poke4_en = 1'b0; poke_addr = '0; poke1_data = '0; poke4_data = '0;
    pat[0] = 16'hACE1;
    for (int i = 1; i < DEPTH; i++) pat[i] = model_step(pat[i-1]);

    test_reset;
    test_fill_verify;
    test_verify_only;
    test_single_error;
    test_back_to_back;
    test_reset_mid_fill;
    test_inverted;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
